// File: rtl/fb_writer.sv
// Framebuffer writer: two-stage clipped pixel draw pipeline plus a full-buffer clear engine.
// Draw and clear writes share the single framebuffer write port and never overlap.
module fb_writer #(
    parameter int CORDW     = 16,
    parameter int FB_WIDTH  = 160,
    parameter int FB_HEIGHT = 120,
    parameter int FB_DATAW  = 4,
    parameter int FB_ADDRW  = $clog2(FB_WIDTH * FB_HEIGHT)
) (
    input  logic                       clk_sys,
    input  logic                       rst_sys,
    input  logic                       pix_valid,
    output logic                       pix_ready,
    input  logic signed [CORDW-1:0]    pix_x,
    input  logic signed [CORDW-1:0]    pix_y,
    input  logic        [FB_DATAW-1:0] pix_colr,
    input  logic                       clear_start,
    input  logic        [FB_DATAW-1:0] clear_colr,
    output logic                       busy,
    output logic                       done,
    output logic                       fb_we,
    output logic        [FB_ADDRW-1:0] fb_addr_write,
    output logic        [FB_DATAW-1:0] fb_colr_write
);

    localparam logic signed [CORDW-1:0] X_LIM  = CORDW'(FB_WIDTH);
    localparam logic signed [CORDW-1:0] Y_LIM  = CORDW'(FB_HEIGHT);
    localparam logic [FB_ADDRW-1:0]     W_ADDR = FB_ADDRW'(FB_WIDTH);
    localparam logic [FB_ADDRW-1:0]     LAST   = FB_ADDRW'(FB_WIDTH * FB_HEIGHT - 1);

    typedef enum logic [1:0] {StIdle, StDrain, StClear, StDone} state_e;

    state_e state_q, state_d;

    logic                accept;
    logic                in_range;
    logic                v1_q, v2_q;
    logic [FB_ADDRW-1:0] x1_q, y1_q;
    logic [FB_DATAW-1:0] colr1_q, colr2_q;
    logic [FB_ADDRW-1:0] addr2_q;
    logic [FB_ADDRW-1:0] clr_addr_q, clr_addr_d;
    logic [FB_DATAW-1:0] clr_colr_q, clr_colr_d;

    assign accept   = pix_valid && pix_ready;
    assign in_range = !pix_x[CORDW-1] && (pix_x < X_LIM) &&
                      !pix_y[CORDW-1] && (pix_y < Y_LIM);

    // Clipped pixels are accepted but never enter the valid chain.
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            v1_q    <= 1'b0;
            x1_q    <= '0;
            y1_q    <= '0;
            colr1_q <= '0;
            v2_q    <= 1'b0;
            addr2_q <= '0;
            colr2_q <= '0;
        end else begin
            v1_q <= accept && in_range;
            if (accept) begin
                x1_q    <= FB_ADDRW'(pix_x);
                y1_q    <= FB_ADDRW'(pix_y);
                colr1_q <= pix_colr;
            end
            v2_q <= v1_q;
            if (v1_q) begin
                addr2_q <= y1_q * W_ADDR + x1_q;
                colr2_q <= colr1_q;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            state_q    <= StIdle;
            clr_addr_q <= '0;
            clr_colr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            clr_colr_q <= clr_colr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_colr_d = clr_colr_q;
        pix_ready  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        unique case (state_q)
            StIdle: begin
                busy      = 1'b0;
                pix_ready = !clear_start;
                if (clear_start) begin
                    state_d    = StDrain;
                    clr_colr_d = clear_colr;
                end
            end
            StDrain: begin
                // Nothing new enters, so stage 2 empties on the same edge we leave.
                clr_addr_d = '0;
                if (!v1_q) state_d = StClear;
            end
            StClear: begin
                if (clr_addr_q == LAST) begin
                    state_d    = StDone;
                    clr_addr_d = '0;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        fb_we         = v2_q;
        fb_addr_write = addr2_q;
        fb_colr_write = colr2_q;
        if (state_q == StClear) begin
            fb_we         = 1'b1;
            fb_addr_write = clr_addr_q;
            fb_colr_write = clr_colr_q;
        end
    end

endmodule

// File: tb/tb_fb_writer.sv
// Bench for fb_writer: directed steps plus random pixels, checked against a write-order
// scoreboard derived from coordinates, clip rules and clear sequencing.
module tb_fb_writer;

    localparam int W  = 160;
    localparam int H  = 120;
    localparam int N  = W * H;
    localparam int AW = 15;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               pix_valid = 1'b0;
    logic               pix_ready;
    logic signed [15:0] pix_x = '0;
    logic signed [15:0] pix_y = '0;
    logic        [3:0]  pix_colr = '0;
    logic               clear_start = 1'b0;
    logic        [3:0]  clear_colr = '0;
    logic               busy, done, fb_we;
    logic      [AW-1:0] fb_addr_write;
    logic        [3:0]  fb_colr_write;

    fb_writer dut (
        .clk_sys       (clk),
        .rst_sys       (rst),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .pix_x         (pix_x),
        .pix_y         (pix_y),
        .pix_colr      (pix_colr),
        .clear_start   (clear_start),
        .clear_colr    (clear_colr),
        .busy          (busy),
        .done          (done),
        .fb_we         (fb_we),
        .fb_addr_write (fb_addr_write),
        .fb_colr_write (fb_colr_write)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected write: address, colour and the cycle window it may appear in.
    typedef struct {
        int addr;
        int colr;
        int lo;
        int hi;
        bit last;
    } wr_t;

    wr_t sb[$];
    wr_t e;
    bit  clr_active = 1'b0;
    int  clr_cyc    = 0;
    int  done_cyc   = -1;
    bit  m_ready, m_busy, m_done;
    int  px, py;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            clr_active = 1'b0;
            done_cyc   = -1;
            chk("rst_we", fb_we, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
        end else begin
            if (clr_active && done_cyc >= 0 && cyc > done_cyc) clr_active = 1'b0;
            m_ready = !clr_active && !clear_start;
            m_busy  = clr_active && cyc > clr_cyc;
            m_done  = done_cyc >= 0 && cyc == done_cyc;
            chk("pix_ready", pix_ready, m_ready);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            if (fb_we) begin
                chk("we_addr_range", fb_addr_write < N, 1);
                if (sb.size() == 0) begin
                    chk("unexpected_we", fb_we, 0);
                end else begin
                    e = sb.pop_front();
                    chk("we_timing", (cyc >= e.lo) && (cyc <= e.hi), 1);
                    chk("we_addr", fb_addr_write, e.addr);
                    chk("we_colr", fb_colr_write, e.colr);
                    if (e.last) done_cyc = cyc + 1;
                end
            end else if (sb.size() > 0 && cyc >= sb[0].hi) begin
                chk("missing_we", fb_we, 1);
                void'(sb.pop_front());
            end
            if (!clr_active && clear_start) begin
                clr_active = 1'b1;
                clr_cyc    = cyc;
                done_cyc   = -1;
                for (int k = 0; k < N; k++)
                    sb.push_back('{addr: k, colr: int'(clear_colr), lo: cyc + 2 + k,
                                   hi: cyc + 3 + k, last: (k == N - 1)});
            end else if (m_ready && pix_valid) begin
                px = pix_x;
                py = pix_y;
                if (px >= 0 && px < W && py >= 0 && py < H)
                    sb.push_back('{addr: py * W + px, colr: int'(pix_colr), lo: cyc + 2,
                                   hi: cyc + 2, last: 1'b0});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pix(input int x, input int y, input int c);
        pix_x    = 16'(x);
        pix_y    = 16'(y);
        pix_colr = 4'(c);
    endtask

    task automatic check_pix(input int x, input int y, input int c, input int exp_addr);
        set_pix(x, y, c);
        pix_valid = 1'b1;
        @(negedge clk);
        chk("dir_ready", pix_ready, 1);
        tick();
        pix_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("dir_we", fb_we, 1);
        chk("dir_addr", fb_addr_write, exp_addr);
        chk("dir_colr", fb_colr_write, c);
        tick();
    endtask

    task automatic wait_done(input bit poke);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < N + 50 && !seen; i++) begin
            @(negedge clk);
            seen = done;
            tick();
            if (poke) begin
                clear_colr  = 4'($urandom);
                clear_start = (i == 100);
            end
        end
        chk("done_seen", seen, 1);
    endtask

    int  cx[4] = '{-1, 160, 0, 0};
    int  cy[4] = '{0, 0, -1, 120};
    bit  found;

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("reset_we", fb_we, 0);
        chk("reset_addr", fb_addr_write, 0);
        chk("reset_colr", fb_colr_write, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        repeat (3) tick();
        rst = 1'b0;
        tick();

        check_pix(3, 2, 5, 323);
        check_pix(0, 0, 9, 0);
        check_pix(159, 119, 14, 19199);

        // Clipped pixels: accepted, never written.
        for (int i = 0; i < 4; i++) begin
            set_pix(cx[i], cy[i], 1);
            pix_valid = 1'b1;
            tick();
        end
        pix_valid = 1'b0;
        repeat (5) tick();

        pix_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            set_pix(int'($urandom_range(0, W - 1)), int'($urandom_range(0, H - 1)),
                    int'($urandom_range(0, 15)));
            tick();
        end
        pix_valid = 1'b0;
        repeat (4) tick();

        for (int i = 0; i < 300; i++) begin
            pix_valid = 1'($urandom_range(0, 1));
            set_pix(int'($urandom_range(0, W + 14)) - 8, int'($urandom_range(0, H + 14)) - 8,
                    int'($urandom_range(0, 15)));
            tick();
        end
        pix_valid = 1'b0;
        repeat (4) tick();

        // Clear with two pixels still in flight; stray clear_start and colour churn ignored.
        pix_valid = 1'b1;
        set_pix(7, 7, 2);
        tick();
        set_pix(8, 9, 11);
        tick();
        pix_valid   = 1'b0;
        clear_start = 1'b1;
        clear_colr  = 4'd7;
        tick();
        clear_start = 1'b0;
        wait_done(1'b1);
        clear_start = 1'b0;
        tick();
        @(negedge clk);
        chk("busy_after_clear", busy, 0);
        tick();

        // Clear and pixel in the same cycle: clear wins, pixel waits.
        set_pix(10, 20, 3);
        pix_valid   = 1'b1;
        clear_start = 1'b1;
        clear_colr  = 4'd2;
        @(negedge clk);
        chk("clear_wins_ready", pix_ready, 0);
        tick();
        clear_start = 1'b0;
        wait_done(1'b0);
        @(negedge clk);
        chk("pix_after_clear", pix_ready, 1);
        tick();
        pix_valid = 1'b0;
        repeat (4) tick();

        // Reset in the middle of a clear.
        clear_start = 1'b1;
        clear_colr  = 4'd3;
        tick();
        clear_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 6000 && !found; i++) begin
            @(negedge clk);
            found = fb_we && (fb_addr_write == 15'd5000);
        end
        chk("reached_5000", found, 1);
        #1 rst = 1'b1;
        #1;
        chk("rst_we_now", fb_we, 0);
        chk("rst_busy_now", busy, 0);
        repeat (2) tick();
        rst = 1'b0;
        check_pix(1, 0, 6, 1);

        repeat (4) tick();
        chk("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fb_writer.md
FB_WRITER -- requirements
Module: fb_writer

Interface
REQ-001 Parameter CORDW, default 16: signed coordinate width (bits).
REQ-002 Parameter FB_WIDTH, default 160: framebuffer width (pixels).
REQ-003 Parameter FB_HEIGHT, default 120: framebuffer height (pixels).
REQ-004 Parameter FB_DATAW, default 4: colour index width (bits); FB_ADDRW = $clog2(FB_WIDTH*FB_HEIGHT), derived.
REQ-005 clk_sys  input  1  system clock; single clock domain.
REQ-006 rst_sys  input  1  reset; asynchronous, active-high.
REQ-007 pix_valid  input  1  pixel write request valid.
REQ-008 pix_ready  output  1  pixel request accepted when pix_valid && pix_ready.
REQ-009 pix_x, pix_y  input  CORDW each (signed)  pixel coordinate.
REQ-010 pix_colr  input  FB_DATAW  pixel colour index.
REQ-011 clear_start  input  1  one-cycle request to fill whole buffer.
REQ-012 clear_colr  input  FB_DATAW  fill colour, sampled when clear_start is taken.
REQ-013 busy  output  1  high while clear pending or in progress.
REQ-014 done  output  1  one-cycle pulse after final clear write.
REQ-015 fb_we  output  1  framebuffer write enable (to bram_sdp write port).
REQ-016 fb_addr_write  output  FB_ADDRW  framebuffer write address.
REQ-017 fb_colr_write  output  FB_DATAW  framebuffer write data.

Function
REQ-018 Address SHALL be y*FB_WIDTH + x, computed at full FB_ADDRW width, no truncation for in-range pixels.
REQ-019 Draw path SHALL be a 2-stage pipeline: pixel accepted in cycle N -> fb_we=1 with its address/colour in cycle N+2.
REQ-020 Sustained throughput SHALL be one pixel per cycle with pix_valid held high.
REQ-021 Clipping: pixel with x<0, x>=FB_WIDTH, y<0 or y>=FB_HEIGHT SHALL be accepted and dropped (no fb_we).
REQ-022 FSM states IDLE, DRAIN, CLEAR, DONE.
REQ-023 IDLE: pix_ready = !clear_start; clear_start -> DRAIN, latch clear_colr.
REQ-024 DRAIN: pix_ready=0; stay until both draw pipeline stages empty (max 2 cycles), then CLEAR.
REQ-025 CLEAR: fb_we=1 every cycle, fb_addr_write 0,1,...,FB_WIDTH*FB_HEIGHT-1 ascending, fb_colr_write=latched colour; after last address -> DONE.
REQ-026 DONE: done=1 for exactly one cycle -> IDLE; pix_ready returns high the following cycle.
REQ-027 busy SHALL be high in DRAIN, CLEAR and DONE; low in IDLE.
REQ-028 clear_start and pix_valid in same IDLE cycle: clear wins, pixel not accepted (pix_ready=0).
REQ-029 clear_start outside IDLE SHALL be ignored; clear_colr changes during clear SHALL NOT affect fill.
REQ-030 fb_we SHALL never be high with an out-of-range address; draw and clear writes never overlap.

Reset
REQ-031 On rst_sys high, asynchronously: state=IDLE, pipeline valids=0, fb_we=0, fb_addr_write=0, fb_colr_write=0, busy=0, done=0.
REQ-032 Reset mid-clear SHALL abort fill immediately with no done pulse; pix_ready=1 in first cycle after release.

Verification
REQ-033 Pixel (3,2,colour 5) accepted at cycle N -> cycle N+2: fb_we=1, addr=323, colr=5; corners (0,0)->0, (159,119)->19199.
REQ-034 Pixels (-1,0), (160,0), (0,-1), (0,120) each accepted -> no fb_we in any cycle.
REQ-035 100 back-to-back valid pixels -> 100 consecutive fb_we cycles, addresses in input order, no pix_ready gaps.
REQ-036 clear_start with clear_colr=7 while 2 pixels in flight -> both pixel writes first, then 19200 writes addr 0..19199 colour 7, one done pulse, busy low after.
REQ-037 clear_start and pix_valid same cycle -> pixel not accepted, clear proceeds; pixel accepted once back in IDLE.
REQ-038 rst_sys asserted at clear addr 5000 -> fb_we=0 immediately, no done, next pixel (1,0) writes addr 1 two cycles after acceptance.
